// File: rtl/mem_stage_ctrl_pkg.sv
// Shared processor package: datapath geometry, data-region base and the
// memory-stage state encoding.
package mem_stage_ctrl_pkg;

  localparam int DATAPATH_WIDTH = 64;
  localparam int REGFILE_ADDR   = 3;
  localparam int MEM_ADDR_WIDTH = 10;
  localparam int DATA_MEM_START = 512;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Memory-stage bundle: upstream op, shared data-memory port and writeback.
// The master modport is the stage itself; slave is its surroundings.
interface mem_stage_ctrl_if #(
  parameter int DATAPATH_WIDTH = mem_stage_ctrl_pkg::DATAPATH_WIDTH,
  parameter int REGFILE_ADDR   = mem_stage_ctrl_pkg::REGFILE_ADDR,
  parameter int MEM_ADDR_WIDTH = mem_stage_ctrl_pkg::MEM_ADDR_WIDTH
);

  logic                      valid_in;
  logic                      WRegEn_in;
  logic                      WMemEn_in;
  logic                      Ld_in;
  logic [DATAPATH_WIDTH-1:0] R1out_in;
  logic [DATAPATH_WIDTH-1:0] R2out_in;
  logic [REGFILE_ADDR-1:0]   WReg1_in;
  logic                      ready_out;

  logic                      dmem_req;
  logic                      dmem_we;
  logic [MEM_ADDR_WIDTH-1:0] dmem_addr;
  logic [DATAPATH_WIDTH-1:0] dmem_wdata;
  logic                      dmem_gnt;
  logic [DATAPATH_WIDTH-1:0] dmem_rdata;

  logic                      wb_valid;
  logic                      wb_WRegEn;
  logic [REGFILE_ADDR-1:0]   wb_WReg1;
  logic [DATAPATH_WIDTH-1:0] wb_data;

  modport master (
    input  valid_in, WRegEn_in, WMemEn_in, Ld_in, R1out_in, R2out_in, WReg1_in,
    output ready_out,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rdata,
    output wb_valid, wb_WRegEn, wb_WReg1, wb_data
  );

  modport slave (
    output valid_in, WRegEn_in, WMemEn_in, Ld_in, R1out_in, R2out_in, WReg1_in,
    input  ready_out,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rdata,
    input  wb_valid, wb_WRegEn, wb_WReg1, wb_data
  );

endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory stage: ALU ops write back after one edge; loads/stores hold a request
// on the shared data memory until granted, then produce one writeback pulse.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATAPATH_WIDTH = mem_stage_ctrl_pkg::DATAPATH_WIDTH,
  parameter int REGFILE_ADDR   = mem_stage_ctrl_pkg::REGFILE_ADDR,
  parameter int MEM_ADDR_WIDTH = mem_stage_ctrl_pkg::MEM_ADDR_WIDTH,
  parameter int DATA_MEM_START = mem_stage_ctrl_pkg::DATA_MEM_START
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_stage_ctrl_if.master     bus
);

  localparam logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = MEM_ADDR_WIDTH'(DATA_MEM_START);

  state_e                    state_q, state_d;
  // Only the offset bits inside the data region are kept; the rest are ignored.
  logic [MEM_ADDR_WIDTH-2:0] addr_q, addr_d;
  logic [DATAPATH_WIDTH-1:0] data_q, data_d;
  logic [REGFILE_ADDR-1:0]   wreg1_q, wreg1_d;
  logic                      wregen_q, wregen_d;
  logic                      store_q, store_d;

  logic                      wb_valid_q, wb_valid_d;
  logic                      wb_wregen_q, wb_wregen_d;
  logic [REGFILE_ADDR-1:0]   wb_wreg1_q, wb_wreg1_d;
  logic [DATAPATH_WIDTH-1:0] wb_data_q, wb_data_d;

  logic                      dmem_req_d;
  logic                      dmem_we_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      wreg1_q     <= '0;
      wregen_q    <= 1'b0;
      store_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_wregen_q <= 1'b0;
      wb_wreg1_q  <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wreg1_q     <= wreg1_d;
      wregen_q    <= wregen_d;
      store_q     <= store_d;
      wb_valid_q  <= wb_valid_d;
      wb_wregen_q <= wb_wregen_d;
      wb_wreg1_q  <= wb_wreg1_d;
      wb_data_q   <= wb_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wreg1_d     = wreg1_q;
    wregen_d    = wregen_q;
    store_d     = store_q;
    wb_valid_d  = 1'b0;
    wb_wregen_d = wb_wregen_q;
    wb_wreg1_d  = wb_wreg1_q;
    wb_data_d   = wb_data_q;
    dmem_req_d  = 1'b0;
    dmem_we_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.valid_in) begin
          if (bus.WMemEn_in || bus.Ld_in) begin
            addr_d   = bus.R1out_in[MEM_ADDR_WIDTH-2:0];
            data_d   = bus.R2out_in;
            wreg1_d  = bus.WReg1_in;
            wregen_d = bus.WRegEn_in;
            // A store flag wins over a simultaneous load flag.
            store_d  = bus.WMemEn_in;
            state_d  = ST_ACCESS;
          end else begin
            wb_valid_d  = 1'b1;
            wb_wregen_d = bus.WRegEn_in;
            wb_wreg1_d  = bus.WReg1_in;
            wb_data_d   = bus.R1out_in;
          end
        end
      end

      ST_ACCESS: begin
        dmem_req_d = 1'b1;
        dmem_we_d  = store_q;
        if (bus.dmem_gnt) begin
          if (store_q) begin
            wb_valid_d  = 1'b1;
            wb_wregen_d = 1'b0;
            wb_wreg1_d  = wreg1_q;
            wb_data_d   = data_q;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_RDATA;
          end
        end
      end

      ST_RDATA: begin
        wb_valid_d  = 1'b1;
        wb_wregen_d = wregen_q;
        wb_wreg1_d  = wreg1_q;
        wb_data_d   = bus.dmem_rdata;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ready_out  = (state_q == ST_IDLE);
  assign bus.dmem_req   = dmem_req_d;
  assign bus.dmem_we    = dmem_we_d;
  assign bus.dmem_addr  = BASE_ADDR + {1'b0, addr_q};
  assign bus.dmem_wdata = data_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_WRegEn  = wb_wregen_q;
  assign bus.wb_WReg1   = wb_wreg1_q;
  assign bus.wb_data    = wb_data_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed and randomized ops on mem_stage_ctrl, each compared against a
// per-op latency/address model derived from the stage's behaviour.
module tb_mem_stage_ctrl;

  localparam int KIND_ALU   = 0;
  localparam int KIND_STORE = 1;
  localparam int KIND_LOAD  = 2;
  localparam int KIND_BOTH  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [63:0] last_data = '0;
  logic [2:0]  last_wreg = '0;
  logic        last_wregen = 1'b0;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.valid_in   = 1'b0;
    bus.WRegEn_in  = 1'($urandom);
    bus.WMemEn_in  = 1'($urandom);
    bus.Ld_in      = 1'($urandom);
    bus.R1out_in   = {$urandom, $urandom};
    bus.R2out_in   = {$urandom, $urandom};
    bus.WReg1_in   = 3'($urandom);
    bus.dmem_gnt   = 1'b0;
    bus.dmem_rdata = {$urandom, $urandom};
  endtask

  task automatic expect_idle_hold(input string tag);
    $display("idle %s: ready=%0b wb_valid=%0b wb_data=%0h", tag, bus.ready_out, bus.wb_valid, bus.wb_data);
    chk({tag, ".ready"}, 64'(bus.ready_out), 64'd1);
    chk({tag, ".wb_valid"}, 64'(bus.wb_valid), 64'd0);
    chk({tag, ".req"}, 64'(bus.dmem_req), 64'd0);
    chk({tag, ".we"}, 64'(bus.dmem_we), 64'd0);
    chk({tag, ".hold_data"}, bus.wb_data, last_data);
    chk({tag, ".hold_wreg"}, 64'(bus.wb_WReg1), 64'(last_wreg));
    chk({tag, ".hold_wregen"}, 64'(bus.wb_WRegEn), 64'(last_wregen));
  endtask

  // Called just after a falling edge with the stage idle; returns one idle cycle later.
  task automatic do_op(input string tag, input int kind, input logic [63:0] r1,
                       input logic [63:0] r2, input logic [2:0] wreg, input logic wregen,
                       input int delay, input logic [63:0] rd);
    logic       is_store;
    logic       is_mem;
    logic [9:0] exp_addr;
    is_store = (kind == KIND_STORE) || (kind == KIND_BOTH);
    is_mem   = (kind != KIND_ALU);
    exp_addr = 10'(64'd512 + (r1 % 64'd512));

    bus.valid_in  = 1'b1;
    bus.WRegEn_in = wregen;
    bus.WMemEn_in = is_store;
    bus.Ld_in     = (kind == KIND_LOAD) || (kind == KIND_BOTH);
    bus.R1out_in  = r1;
    bus.R2out_in  = r2;
    bus.WReg1_in  = wreg;
    chk({tag, ".ready_pre"}, 64'(bus.ready_out), 64'd1);
    @(negedge clk);
    scramble_inputs();

    if (!is_mem) begin
      chk({tag, ".wb_valid"}, 64'(bus.wb_valid), 64'd1);
      chk({tag, ".wb_data"}, bus.wb_data, r1);
      chk({tag, ".wb_wreg"}, 64'(bus.wb_WReg1), 64'(wreg));
      chk({tag, ".wb_wregen"}, 64'(bus.wb_WRegEn), 64'(wregen));
      chk({tag, ".ready"}, 64'(bus.ready_out), 64'd1);
      chk({tag, ".req"}, 64'(bus.dmem_req), 64'd0);
      last_data = r1; last_wreg = wreg; last_wregen = wregen;
    end else begin
      for (int i = 0; i <= delay; i++) begin
        chk({tag, ".acc_ready"}, 64'(bus.ready_out), 64'd0);
        chk({tag, ".acc_req"}, 64'(bus.dmem_req), 64'd1);
        chk({tag, ".acc_we"}, 64'(bus.dmem_we), 64'(is_store));
        chk({tag, ".acc_addr"}, 64'(bus.dmem_addr), 64'(exp_addr));
        if (is_store) chk({tag, ".acc_wdata"}, bus.dmem_wdata, r2);
        chk({tag, ".acc_wb_valid"}, 64'(bus.wb_valid), 64'd0);
        bus.dmem_gnt = (i == delay);
        @(negedge clk);
        bus.dmem_gnt   = 1'b0;
        bus.dmem_rdata = {$urandom, $urandom};
      end
      if (is_store) begin
        chk({tag, ".st_wb_valid"}, 64'(bus.wb_valid), 64'd1);
        chk({tag, ".st_wb_wregen"}, 64'(bus.wb_WRegEn), 64'd0);
        chk({tag, ".st_wb_data"}, bus.wb_data, r2);
        chk({tag, ".st_wb_wreg"}, 64'(bus.wb_WReg1), 64'(wreg));
        chk({tag, ".st_ready"}, 64'(bus.ready_out), 64'd1);
        chk({tag, ".st_req"}, 64'(bus.dmem_req), 64'd0);
        last_data = r2; last_wreg = wreg; last_wregen = 1'b0;
      end else begin
        chk({tag, ".rd_ready"}, 64'(bus.ready_out), 64'd0);
        chk({tag, ".rd_req"}, 64'(bus.dmem_req), 64'd0);
        chk({tag, ".rd_wb_valid"}, 64'(bus.wb_valid), 64'd0);
        bus.dmem_rdata = rd;
        @(negedge clk);
        bus.dmem_rdata = {$urandom, $urandom};
        chk({tag, ".ld_wb_valid"}, 64'(bus.wb_valid), 64'd1);
        chk({tag, ".ld_wb_data"}, bus.wb_data, rd);
        chk({tag, ".ld_wb_wregen"}, 64'(bus.wb_WRegEn), 64'(wregen));
        chk({tag, ".ld_wb_wreg"}, 64'(bus.wb_WReg1), 64'(wreg));
        chk({tag, ".ld_ready"}, 64'(bus.ready_out), 64'd1);
        last_data = rd; last_wreg = wreg; last_wregen = wregen;
      end
    end
    $display("op %s kind=%0d r1=%0h addr=%0d wb_data=%0h", tag, kind, r1, exp_addr, bus.wb_data);
    @(negedge clk);
    expect_idle_hold({tag, ".after"});
  endtask

  initial begin
    scramble_inputs();
    #12;
    chk("reset.ready", 64'(bus.ready_out), 64'd1);
    chk("reset.wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("reset.wb_data", bus.wb_data, 64'd0);
    chk("reset.wb_wreg", 64'(bus.wb_WReg1), 64'd0);
    chk("reset.req", 64'(bus.dmem_req), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expect_idle_hold("post_reset");

    do_op("alu_1234", KIND_ALU, 64'h1234, 64'h0, 3'd5, 1'b1, 0, 64'h0);
    do_op("store_7", KIND_STORE, 64'd7, 64'hAA, 3'd2, 1'b1, 0, 64'h0);
    do_op("load_3_wait4", KIND_LOAD, 64'd3, 64'h0, 3'd6, 1'b1, 4, 64'h55);
    do_op("both_is_store", KIND_BOTH, 64'd20, 64'hBEEF, 3'd1, 1'b1, 1, 64'h0);
    do_op("addr_wrap", KIND_LOAD, 64'hFFFF_0201, 64'h0, 3'd3, 1'b0, 0, 64'hC0FFEE);

    // Reset asserted while a load is waiting for its grant.
    bus.valid_in  = 1'b1;
    bus.Ld_in     = 1'b1;
    bus.WMemEn_in = 1'b0;
    bus.WRegEn_in = 1'b1;
    bus.R1out_in  = 64'd9;
    @(negedge clk);
    scramble_inputs();
    chk("midreset.req_before", 64'(bus.dmem_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    $display("midreset: req=%0b ready=%0b wb_valid=%0b", bus.dmem_req, bus.ready_out, bus.wb_valid);
    chk("midreset.req", 64'(bus.dmem_req), 64'd0);
    chk("midreset.we", 64'(bus.dmem_we), 64'd0);
    chk("midreset.ready", 64'(bus.ready_out), 64'd1);
    chk("midreset.wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("midreset.wb_data", bus.wb_data, 64'd0);
    last_data = '0; last_wreg = '0; last_wregen = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.dmem_gnt = 1'b1;
      @(negedge clk);
      bus.dmem_gnt = 1'b0;
      expect_idle_hold("midreset.release");
    end

    for (int n = 0; n < 40; n++) begin
      do_op($sformatf("rand%0d", n), int'($urandom_range(0, 3)), {$urandom, $urandom},
            {$urandom, $urandom}, 3'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have parameter DATAPATH_WIDTH, default 64, meaning the data word width.
REQ-002 The block SHALL have parameter REGFILE_ADDR, default 3, meaning the register-index width.
REQ-003 The block SHALL have parameter MEM_ADDR_WIDTH, default 10, meaning the data-memory address width.
REQ-004 The block SHALL have parameter DATA_MEM_START, default 512, meaning the base address of the data region.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge) and reset input 1 (0 = reset asserted).
REQ-006 valid_in  input  1  execute/mem register holds an op.
REQ-007 WRegEn_in  input  1  op writes the register file.
REQ-008 WMemEn_in  input  1  op is a store.
REQ-009 Ld_in  input  1  op is a load.
REQ-010 R1out_in  input  DATAPATH_WIDTH  ALU result or memory address.
REQ-011 R2out_in  input  DATAPATH_WIDTH  store data.
REQ-012 WReg1_in  input  REGFILE_ADDR  destination register.
REQ-013 ready_out  output  1  block can accept an op; upstream drives its pipeline-register en from this signal.
REQ-014 dmem_req, dmem_we  output  1 each  memory request and write strobe.
REQ-015 dmem_addr  output  MEM_ADDR_WIDTH; dmem_wdata  output  DATAPATH_WIDTH.
REQ-016 dmem_gnt  input  1  shared-memory arbiter grant; dmem_rdata  input  DATAPATH_WIDTH  valid one cycle after a read grant.
REQ-017 wb_valid, wb_WRegEn  output  1 each; wb_WReg1  output  REGFILE_ADDR; wb_data  output  DATAPATH_WIDTH  writeback bundle.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and RDATA.
REQ-019 ready_out SHALL be 1 exactly when the state is IDLE.
REQ-020 An op SHALL be accepted on a rising edge where valid_in=1 and ready_out=1.
REQ-021 An accepted ALU op (WMemEn_in=0, Ld_in=0) SHALL stay in IDLE and, on the next edge, set wb_valid=1, wb_WRegEn=WRegEn_in, wb_WReg1=WReg1_in and wb_data=R1out_in, giving latency 1.
REQ-022 An accepted store or load SHALL latch addr, data, WReg1, WRegEn and the op type, then move to ACCESS.
REQ-023 When WMemEn_in=1 and Ld_in=1 together, the op SHALL be treated as a store.
REQ-024 In ACCESS, the block SHALL drive dmem_req=1 and dmem_addr = DATA_MEM_START + latched_addr[MEM_ADDR_WIDTH-2:0]; upper address bits SHALL be ignored.
REQ-025 In ACCESS, dmem_we=1 and dmem_wdata = latched data SHALL be driven for a store, and dmem_we=0 for a load.
REQ-026 ACCESS SHALL be held with request signals stable until dmem_gnt=1; there SHALL be no timeout.
REQ-027 On a store grant: next state IDLE; next edge sets wb_valid=1, wb_WRegEn=0 and wb_data=latched data.
REQ-028 On a load grant: next state RDATA.
REQ-029 In RDATA, the block SHALL capture dmem_rdata into wb_data, set wb_valid=1 and wb_WRegEn = latched WRegEn, and return to IDLE; with an immediate grant this gives load latency 3 and store latency 2.
REQ-030 wb_valid SHALL be a one-cycle pulse per op; all wb_* outputs SHALL hold their values when wb_valid=0.
REQ-031 dmem_req and dmem_we SHALL be 0 outside ACCESS.
REQ-032 valid_in=0 in IDLE SHALL produce no state change and wb_valid=0.

Reset
REQ-033 Asserting reset (0) SHALL immediately force state IDLE and set wb_valid, wb_WRegEn, wb_WReg1, wb_data and all latches to 0; dmem_req=0 and dmem_we=0.
REQ-034 Reset during ACCESS or RDATA SHALL abandon the op, with no writeback pulse after release.
REQ-035 ready_out SHALL be 1 from the first edge after reset is released.

Structure
REQ-036 DATAPATH_WIDTH, REGFILE_ADDR, MEM_ADDR_WIDTH, DATA_MEM_START and the state encoding SHALL reside in the shared processor package.
REQ-037 The block SHALL be a single module with no sub-modules.

Verification
REQ-038 ALU op, R1out_in=64'h1234, WReg1_in=5, WRegEn_in=1 -> next cycle wb_valid=1, wb_data=64'h1234, wb_WReg1=5, ready_out stays 1.
REQ-039 Store, addr 7, data 64'hAA, dmem_gnt=1 immediately -> dmem_addr=519, dmem_we=1 for 1 cycle, then wb_valid=1 with wb_WRegEn=0.
REQ-040 Load, addr 3, grant withheld 4 cycles, then dmem_rdata=64'h55 -> dmem_req high for 5 cycles with constant addr 515, ready_out=0 throughout, wb_data=64'h55 on the single wb_valid pulse.
REQ-041 Load with WMemEn_in=1 and Ld_in=1 -> treated as a store (dmem_we=1).
REQ-042 Reset asserted mid-ACCESS -> dmem_req drops immediately, no wb_valid after release, ready_out=1.
REQ-043 Address 64'hFFFF_0201 -> dmem_addr = 512 + 9'h001 = 513.
